// File: rtl/cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-through data cache.
package cache_pkg;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 32;
  localparam int INDEX_W     = 5;
  localparam int OFFSET_W    = 2;
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_WORDS = 1 << OFFSET_W;
  localparam int LINES       = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    WRITE = 2'b10
  } state_e;

endpackage

// File: rtl/cache_controller_if.sv
// Core-side and memory-side bus of the data cache.
// The slave modport is the cache itself; master is the surrounding core/memory environment.
interface cache_controller_if;
  import cache_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata, mem_ack,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata, mem_ack,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_array.sv
// Valid/tag/data storage: asynchronous read port, synchronous write port.
// Only the valid bits are reset; tag and data contents are meaningless until a line is filled.
module cache_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [DATA_W-1:0]   rd_data,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                word_we,
  input  logic                set_valid,
  input  logic                clr_valid
);

  logic [DATA_W-1:0] data_mem [LINES*BLOCK_WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (clr_valid) valid_d[wr_index] = 1'b0;
    if (set_valid) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (word_we)   data_mem[{wr_index, wr_offset}] <= wr_data;
    if (set_valid) tag_mem[wr_index] <= wr_tag;
  end

  assign rd_data  = data_mem[{rd_index, rd_offset}];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return in the same cycle; misses fill a whole block; every store is one memory write beat.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cache_controller_if.slave bus
);

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;

  logic [TAG_W-1:0]    cpu_tag, cap_tag, arr_tag;
  logic [INDEX_W-1:0]  cpu_index, cap_index, wr_index;
  logic [OFFSET_W-1:0] cpu_offset, wr_offset;
  logic [DATA_W-1:0]   arr_data, wr_data;
  logic                arr_valid, hit, word_we, set_valid, clr_valid;
  logic                stall, mem_req, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  assign cpu_tag    = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_index  = bus.cpu_addr[OFFSET_W +: INDEX_W];
  assign cpu_offset = bus.cpu_addr[OFFSET_W-1:0];
  assign cap_tag    = cap_addr_q[ADDR_W-1 -: TAG_W];
  assign cap_index  = cap_addr_q[OFFSET_W +: INDEX_W];
  assign hit        = arr_valid && (arr_tag == cpu_tag);

  cache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (cpu_index),
    .rd_offset (cpu_offset),
    .rd_data   (arr_data),
    .rd_tag    (arr_tag),
    .rd_valid  (arr_valid),
    .wr_index  (wr_index),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .wr_tag    (cap_tag),
    .word_we   (word_we),
    .set_valid (set_valid),
    .clr_valid (clr_valid)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    wr_index    = cpu_index;
    wr_offset   = cpu_offset;
    wr_data     = bus.cpu_wdata;
    word_we     = 1'b0;
    set_valid   = 1'b0;
    clr_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_wr) begin
          stall       = 1'b1;
          word_we     = hit;
          cap_addr_d  = bus.cpu_addr;
          cap_wdata_d = bus.cpu_wdata;
          state_d     = WRITE;
        end else if (bus.cpu_rd && !hit) begin
          // Invalidate up front so a half-filled line can never produce a hit.
          stall      = 1'b1;
          clr_valid  = 1'b1;
          cap_addr_d = {bus.cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          beat_d     = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {cap_addr_q[ADDR_W-1:OFFSET_W], beat_q};
        wr_index  = cap_index;
        wr_offset = beat_q;
        wr_data   = bus.mem_rdata;
        if (bus.mem_ack) begin
          word_we = 1'b1;
          beat_d  = beat_q + OFFSET_W'(1);
          if (beat_q == OFFSET_W'(BLOCK_WORDS - 1)) begin
            set_valid = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cap_addr_q;
        mem_wdata = cap_wdata_q;
        stall     = !bus.mem_ack;
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  // Core-facing outputs are forced quiet while reset is held, even if the core keeps requesting.
  assign bus.stall     = stall && rst;
  assign bus.cpu_rdata = rst ? arr_data : '0;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller: a reference memory plus a block-residency
// table predict load data, hit/miss and the exact memory beats; a monitor checks what the DUT presents.
module tb_cache_controller;
  import cache_pkg::*;

  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } beat_t;

  typedef struct {
    logic              is_wr;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

  logic clk;
  logic rst;

  cache_controller_if bus();

  cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int stall_run = 0;
  int fixed_lat = -1;

  logic [DATA_W-1:0] ref_mem  [MEM_WORDS];
  logic [DATA_W-1:0] phys_mem [MEM_WORDS];
  int                cached_block [LINES];
  beat_t             beat_exp [$];
  op_t               op_exp [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  endtask

  task automatic forget_cache();
    for (int i = 0; i < LINES; i++) cached_block[i] = -1;
  endtask

  // Reference behaviour: stores go straight to memory, loads return memory contents,
  // and a load to a block not resident in its line fetches the whole block.
  task automatic push_expect(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
    beat_t b;
    op_t   o;
    int    blk;
    int    idx;
    blk = int'(addr) / BLOCK_WORDS;
    idx = blk % LINES;
    if (wr) begin
      b.we = 1'b1; b.addr = addr; b.wdata = wdata;
      beat_exp.push_back(b);
      ref_mem[addr] = wdata;
      o.is_wr = 1'b1; o.hit = 1'b0; o.addr = addr; o.data = wdata;
      op_exp.push_back(o);
    end else if (rd) begin
      o.is_wr = 1'b0;
      o.addr  = addr;
      o.hit   = (cached_block[idx] == blk);
      o.data  = ref_mem[addr];
      if (!o.hit) begin
        for (int k = 0; k < BLOCK_WORDS; k++) begin
          b.we = 1'b0; b.addr = ADDR_W'(blk * BLOCK_WORDS + k); b.wdata = '0;
          beat_exp.push_back(b);
        end
        cached_block[idx] = blk;
      end
      op_exp.push_back(o);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    @(posedge clk);
    #1;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata);
    bit done;
    done = 1'b0;
    push_expect(rd, wr, addr, wdata);
    drive(rd, wr, addr, wdata);
    if (rd || wr) begin
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk);
        if (!bus.stall) done = 1'b1;
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL op_timeout: addr=0x%0h still stalled after 400 cycles", addr);
        finish_run();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_stall"},     bus.stall,     '0);
    check_output({tag, "_mem_req"},   bus.mem_req,   '0);
    check_output({tag, "_mem_we"},    bus.mem_we,    '0);
    check_output({tag, "_mem_addr"},  bus.mem_addr,  '0);
    check_output({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    check_output({tag, "_cpu_rdata"}, bus.cpu_rdata, '0);
  endtask

  // Memory model: random (or fixed) ack latency per beat, and stray acks while no request is open.
  initial begin : responder
    int  lat_left;
    bit  armed;
    lat_left      = 0;
    armed         = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst && bus.mem_req) begin
        if (!armed) begin
          lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          armed    = 1'b1;
        end
        if (lat_left == 0) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) phys_mem[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = phys_mem[bus.mem_addr];
          armed = 1'b0;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
          lat_left--;
        end
      end else begin
        armed         = 1'b0;
        bus.mem_ack   = ($urandom_range(0, 7) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    beat_t b;
    op_t   o;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_run = 0;
      end else begin
        if (bus.mem_req && bus.mem_ack) begin
          check_output("beat_expected", 64'(beat_exp.size() != 0), 64'd1);
          if (beat_exp.size() != 0) begin
            b = beat_exp.pop_front();
            check_output("beat_we",   bus.mem_we,   b.we);
            check_output("beat_addr", bus.mem_addr, b.addr);
            if (b.we) check_output("beat_wdata", bus.mem_wdata, b.wdata);
          end
        end
        if (bus.cpu_rd || bus.cpu_wr) begin
          if (bus.stall) begin
            stall_run++;
          end else begin
            check_output("op_expected", 64'(op_exp.size() != 0), 64'd1);
            if (op_exp.size() != 0) begin
              o = op_exp.pop_front();
              check_output("op_kind", bus.cpu_wr, o.is_wr);
              if (o.is_wr) begin
                check_output("wr_retire_on_ack", 64'(bus.mem_req && bus.mem_we && bus.mem_ack), 64'd1);
              end else begin
                check_output("rd_data", bus.cpu_rdata, o.data);
                check_output("rd_hit",  64'(stall_run == 0), 64'(o.hit));
              end
            end
            stall_run = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit               done;
    int               r;
    logic [ADDR_W-1:0] a;

    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      ref_mem[i]  = $urandom;
      phys_mem[i] = ref_mem[i];
    end
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      ref_mem[16 + k]  = DATA_W'(32'hA0 + k);
      phys_mem[16 + k] = ref_mem[16 + k];
    end
    forget_cache();

    rst = 1'b1;
    #3 rst = 1'b0;
    #4;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    fixed_lat = 1;
    apply_stimulus(1'b1, 1'b0, 10'h012, '0);
    apply_stimulus(1'b1, 1'b0, 10'h013, '0);
    fixed_lat = 3;
    apply_stimulus(1'b0, 1'b1, 10'h011, 32'hDEADBEEF);
    fixed_lat = -1;
    apply_stimulus(1'b1, 1'b0, 10'h011, '0);
    apply_stimulus(1'b0, 1'b1, 10'h200, 32'h12345678);
    apply_stimulus(1'b1, 1'b0, 10'h200, '0);
    apply_stimulus(1'b1, 1'b1, 10'h013, 32'hCAFEF00D);
    apply_stimulus(1'b1, 1'b0, 10'h092, '0);
    apply_stimulus(1'b1, 1'b0, 10'h012, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b1, 1'b0, 10'h092, '0);

    // Abort a fill after its second beat has been accepted.
    push_expect(1'b1, 1'b0, 10'h012, '0);
    drive(1'b1, 1'b0, 10'h012, '0);
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      if (beat_exp.size() == 2) done = 1'b1;
    end
    check_output("fill_two_beats_seen", 64'(done), 64'd1);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    beat_exp.delete();
    op_exp.delete();
    forget_cache();
    bus.cpu_rd = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 10'h012, '0);
    apply_stimulus(1'b1, 1'b0, 10'h012, '0);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      a = ADDR_W'(($urandom_range(0, 7) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      if (r < 5)       apply_stimulus(1'b1, 1'b0, a, '0);
      else if (r < 8)  apply_stimulus(1'b0, 1'b1, a, $urandom);
      else if (r == 8) apply_stimulus(1'b1, 1'b1, a, $urandom);
      else             apply_stimulus(1'b0, 1'b0, a, '0);
    end

    apply_stimulus(1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    check_output("beats_left", 64'(beat_exp.size()), 64'd0);
    check_output("ops_left",   64'(op_exp.size()),   64'd0);
    finish_run();
  end

endmodule
